// File: rtl/or4_chk_pkg.sv
// Shared types and golden model for the four-input OR response checker.
package or4_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] FULL_COV = 16'hFFFF;

  // Expected {e,f,g} for vec = {a,b,c,d}.
  function automatic logic [2:0] or4_golden(input logic [3:0] vec);
    or4_golden = {vec[3] | vec[2], vec[1] | vec[0], |vec};
  endfunction

endpackage

// File: rtl/or4_response_checker_if.sv
// Stimulus/response and result bundle between a bench driver and the OR4 checker.
interface or4_response_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             sample_valid;
  logic [3:0]       vec_in;
  logic [2:0]       resp_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       first_err_vec;
  logic [15:0]      coverage;

  modport master (
    output start, sample_valid, vec_in, resp_in,
    input  busy, done, pass, timeout, err_pulse, err_cnt, first_err_vec, coverage
  );

  modport slave (
    input  start, sample_valid, vec_in, resp_in,
    output busy, done, pass, timeout, err_pulse, err_cnt, first_err_vec, coverage
  );
endinterface

// File: rtl/or4_golden_model.sv
// Combinational reference for the four-input OR DUT: {e,f,g} from {a,b,c,d}.
module or4_golden_model
  import or4_chk_pkg::*;
(
  input  logic [3:0] vec,
  output logic [2:0] exp_resp
);

  assign exp_resp = or4_golden(vec);

endmodule

// File: rtl/or4_response_checker.sv
// Self-checking monitor: compares sampled OR4 responses against the golden model,
// counts mismatches, tracks input coverage and reports a pass/fail verdict.
module or4_response_checker
  import or4_chk_pkg::*;
#(
  parameter int unsigned NUM_VEC     = 16,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  or4_response_checker_if.slave bus
);

  localparam int unsigned     TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [15:0]     VEC_LAST = 16'(NUM_VEC - 1);

  state_t           state_q, state_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       first_err_vec_q, first_err_vec_d;
  logic [15:0]      coverage_q, coverage_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             err_pulse_q, err_pulse_d;

  logic [2:0] exp_resp;
  logic       mismatch;
  logic       last_sample;
  logic       tmo_hit;
  logic       start_run;

  or4_golden_model u_golden (
    .vec      (bus.vec_in),
    .exp_resp (exp_resp)
  );

  assign mismatch    = (bus.resp_in != exp_resp);
  assign last_sample = bus.sample_valid && (vec_cnt_q == VEC_LAST);
  assign tmo_hit     = (TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d         = state_q;
    vec_cnt_d       = vec_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_vec_d = first_err_vec_q;
    coverage_d      = coverage_q;
    pass_d          = pass_q;
    timeout_d       = timeout_q;
    err_pulse_d     = 1'b0;
    start_run       = 1'b0;

    case (state_q)
      IDLE: start_run = bus.start;
      RUN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (bus.sample_valid) begin
          coverage_d[bus.vec_in] = 1'b1;
          vec_cnt_d              = vec_cnt_q + 16'd1;
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q == '0) first_err_vec_d = bus.vec_in;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        // A final sample arriving on the timeout cycle wins: the run completes normally.
        if (last_sample || tmo_hit) begin
          state_d   = DONE;
          timeout_d = tmo_hit && !last_sample;
          pass_d    = (err_cnt_d == '0) && (coverage_d == FULL_COV) && !timeout_d;
        end
      end
      DONE: start_run = bus.start;
      default: state_d = IDLE;
    endcase

    if (start_run) begin
      state_d         = RUN;
      vec_cnt_d       = '0;
      tmo_cnt_d       = '0;
      err_cnt_d       = '0;
      first_err_vec_d = '0;
      coverage_d      = '0;
      pass_d          = 1'b0;
      timeout_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      vec_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      err_cnt_q       <= '0;
      first_err_vec_q <= '0;
      coverage_q      <= '0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_pulse_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      vec_cnt_q       <= vec_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_vec_q <= first_err_vec_d;
      coverage_q      <= coverage_d;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
      err_pulse_q     <= err_pulse_d;
    end
  end

  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.coverage      = coverage_q;

endmodule

// File: tb/tb_or4_response_checker.sv
// Bench for or4_response_checker: table-driven sweeps with a per-sample scoreboard,
// plus hand-written timeout, saturation, restart and reset sequences.
module tb_or4_response_checker;

  typedef struct {
    logic [3:0] vec;
    logic [2:0] resp;
    logic       exp_err;
  } samp_t;

  typedef struct {
    logic       pulse;
    logic [7:0] cnt;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  or4_response_checker_if #(.ERR_W(8)) ifa ();
  or4_response_checker_if #(.ERR_W(2)) ifb ();

  or4_response_checker #(.NUM_VEC(16), .ERR_W(8), .TIMEOUT_CYC(32)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  or4_response_checker #(.NUM_VEC(16), .ERR_W(2), .TIMEOUT_CYC(1024)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  samp_t      clean_t [16];
  samp_t      fault_t [16];
  samp_t      hole_t  [16];
  samp_t      seq     [16];
  sb_t        sbq [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_cnt;
  int         m_pulses;

  function automatic logic [2:0] ref_or(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {a | b, c | d, a | b | c | d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("a_start_busy", 32'(ifa.busy), 32'd1);
    chk("a_start_cleared", 32'({ifa.done, ifa.pass, ifa.timeout, ifa.err_pulse,
                                ifa.err_cnt, ifa.first_err_vec, ifa.coverage}), 32'd0);
    m_cnt    = '0;
    m_pulses = 0;
  endtask

  task automatic send_a(input logic [3:0] v, input logic [2:0] r, input logic e);
    sb_t x;
    ifa.sample_valid = 1'b1;
    ifa.vec_in       = v;
    ifa.resp_in      = r;
    if (e && m_cnt != 8'hFF) m_cnt++;
    x.pulse = e;
    x.cnt   = m_cnt;
    sbq.push_back(x);
    tick();
    ifa.sample_valid = 1'b0;
    x = sbq.pop_front();
    chk("a_err_pulse", 32'(ifa.err_pulse), 32'(x.pulse));
    chk("a_err_cnt", 32'(ifa.err_cnt), 32'(x.cnt));
    if (ifa.err_pulse) m_pulses++;
  endtask

  task automatic run_seq(input logic [3:0] e_first, input logic [15:0] e_cov,
                         input logic e_pass, input logic [7:0] e_cnt, input int e_pulses);
    start_a();
    for (int i = 0; i < 16; i++) begin
      send_a(seq[i].vec, seq[i].resp, seq[i].exp_err);
      chk("run_done_timing", 32'(ifa.done), (i == 15) ? 32'd1 : 32'd0);
    end
    chk("run_busy_end", 32'(ifa.busy), 32'd0);
    chk("run_pass", 32'(ifa.pass), 32'(e_pass));
    chk("run_err_cnt", 32'(ifa.err_cnt), 32'(e_cnt));
    chk("run_first_err", 32'(ifa.first_err_vec), 32'(e_first));
    chk("run_coverage", 32'(ifa.coverage), 32'(e_cov));
    chk("run_timeout", 32'(ifa.timeout), 32'd0);
    chk("run_pulse_count", 32'(m_pulses), 32'(e_pulses));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] hv [16];
    int         k;
    int         pulses;
    logic [1:0] b_cnt;

    for (int i = 0; i < 16; i++) begin
      clean_t[i].vec     = 4'(i);
      clean_t[i].resp    = ref_or(4'(i));
      clean_t[i].exp_err = 1'b0;
    end
    fault_t = clean_t;
    fault_t[5].resp = 3'b010; fault_t[5].exp_err = 1'b1;
    fault_t[8].resp = 3'b000; fault_t[8].exp_err = 1'b1;
    hv = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6,
           4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    for (int i = 0; i < 16; i++) begin
      hole_t[i].vec     = hv[i];
      hole_t[i].resp    = ref_or(hv[i]);
      hole_t[i].exp_err = 1'b0;
    end

    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.sample_valid = 1'b0; ifa.vec_in = '0; ifa.resp_in = '0;
    ifb.start = 1'b0; ifb.sample_valid = 1'b0; ifb.vec_in = '0; ifb.resp_in = '0;
    tick();
    tick();
    chk("reset_flags", 32'({ifa.busy, ifa.done, ifa.pass, ifa.timeout, ifa.err_pulse}), 32'd0);
    chk("reset_regs", 32'({ifa.err_cnt, ifa.first_err_vec, ifa.coverage}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Clean sweep, then results must hold while further samples arrive in DONE.
    seq = clean_t;
    run_seq(4'd0, 16'hFFFF, 1'b1, 8'd0, 0);
    ifa.sample_valid = 1'b1; ifa.vec_in = 4'd7; ifa.resp_in = 3'b000;
    tick();
    tick();
    ifa.sample_valid = 1'b0;
    chk("done_hold_err_cnt", 32'(ifa.err_cnt), 32'd0);
    chk("done_hold_pulse", 32'(ifa.err_pulse), 32'd0);
    chk("done_hold_done_pass", 32'({ifa.done, ifa.pass}), 32'd3);

    // Injected faults; start from DONE must clear the prior results.
    seq = fault_t;
    run_seq(4'b0101, 16'hFFFF, 1'b0, 8'd2, 2);

    // Coverage hole with no mismatches.
    seq = hole_t;
    run_seq(4'd0, 16'hEFFF, 1'b0, 8'd0, 0);

    // Timeout after only five samples.
    start_a();
    for (int i = 0; i < 5; i++) send_a(4'(i), ref_or(4'(i)), 1'b0);
    k = 5;
    while (!ifa.done && k < 40) begin
      tick();
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'd32);
    chk("tmo_flag", 32'(ifa.timeout), 32'd1);
    chk("tmo_pass", 32'(ifa.pass), 32'd0);
    chk("tmo_coverage", 32'(ifa.coverage), 32'h001F);
    chk("tmo_busy", 32'(ifa.busy), 32'd0);

    // Final sample lands on the timeout cycle: counted, no timeout.
    start_a();
    for (int i = 0; i < 15; i++) send_a(4'(i), ref_or(4'(i)), 1'b0);
    repeat (16) tick();
    chk("tmo_edge_not_done", 32'(ifa.done), 32'd0);
    send_a(4'd15, ref_or(4'd15), 1'b0);
    chk("tmo_edge_done", 32'(ifa.done), 32'd1);
    chk("tmo_edge_timeout", 32'(ifa.timeout), 32'd0);
    chk("tmo_edge_pass", 32'(ifa.pass), 32'd1);

    // start while in RUN is ignored: partial coverage and vector count survive.
    start_a();
    for (int i = 0; i < 3; i++) send_a(4'(i), ref_or(4'(i)), 1'b0);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("run_start_ignored_busy", 32'(ifa.busy), 32'd1);
    chk("run_start_ignored_cov", 32'(ifa.coverage), 32'h0007);
    for (int i = 3; i < 16; i++) send_a(4'(i), ref_or(4'(i)), 1'b0);
    chk("run_start_ignored_done", 32'({ifa.done, ifa.pass}), 32'd3);

    // Saturation on the 2-bit counter instance.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    pulses = 0;
    b_cnt  = '0;
    for (int i = 0; i < 16; i++) begin
      ifb.sample_valid = 1'b1;
      ifb.vec_in       = 4'(i);
      ifb.resp_in      = ~ref_or(4'(i));
      if (b_cnt != 2'b11) b_cnt++;
      tick();
      if (ifb.err_pulse) pulses++;
      chk("sat_err_cnt", 32'(ifb.err_cnt), 32'(b_cnt));
    end
    ifb.sample_valid = 1'b0;
    chk("sat_pulses", 32'(pulses), 32'd16);
    chk("sat_final_cnt", 32'(ifb.err_cnt), 32'd3);
    chk("sat_done_pass", 32'({ifb.done, ifb.pass}), 32'd2);
    chk("sat_first_err", 32'(ifb.first_err_vec), 32'd0);

    // Reset mid-run clears everything asynchronously, then IDLE ignores samples.
    start_a();
    for (int i = 0; i < 7; i++)
      send_a(4'(i + 1), (i == 2) ? ~ref_or(4'(i + 1)) : ref_or(4'(i + 1)), i == 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 32'({ifa.busy, ifa.done, ifa.pass, ifa.timeout, ifa.err_pulse}), 32'd0);
    chk("midrst_regs", 32'({ifa.err_cnt, ifa.first_err_vec, ifa.coverage}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.sample_valid = 1'b1; ifa.vec_in = 4'd5; ifa.resp_in = 3'b000;
    tick();
    ifa.sample_valid = 1'b0;
    chk("idle_ignores_sample", 32'({ifa.busy, ifa.done, ifa.err_pulse, ifa.err_cnt}), 32'd0);
    chk("idle_cov", 32'(ifa.coverage), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
